// File: rtl/instr_boot_pkg.sv
// Command and state encodings plus PIO field positions shared by the instruction boot sequencer.
package instr_boot_pkg;

    typedef enum logic [1:0] {
        CMD_DATA    = 2'b00,
        CMD_ADDR_LO = 2'b01,
        CMD_ADDR_HI = 2'b10,
        CMD_COMMIT  = 2'b11
    } cmd_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        HOLD = 2'b10,
        ERR  = 2'b11
    } state_e;

    localparam int PIO_W      = 11;
    localparam int PIO_TOGGLE = 10;
    localparam int PIO_CMD_HI = 9;
    localparam int PIO_CMD_LO = 8;
    localparam int PIO_PAY_HI = 7;
    localparam int PIO_PAY_LO = 0;

endpackage

// File: rtl/boot_word_packer.sv
// Packs payload bytes little-endian into an INSTR_W-bit word; the last lane's byte is
// merged combinationally so the caller can write the finished word in the same cycle.
module boot_word_packer
    import instr_boot_pkg::*;
#(
    parameter int INSTR_W = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic [INSTR_W-1:0] word,
    output logic               last_lane,
    output logic               partial
);

    localparam int LANES = INSTR_W / 8;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [INSTR_W-1:0] lanes_q;
    logic [CNT_W-1:0]   cnt_q;

    always_comb begin
        word = lanes_q;
        for (int i = 0; i < LANES; i++) begin
            if (cnt_q == CNT_W'(i)) begin
                word[i*8 +: 8] = byte_data;
            end
        end
    end

    assign last_lane = (cnt_q == CNT_W'(LANES - 1));
    assign partial   = (cnt_q != '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lanes_q <= '0;
            cnt_q   <= '0;
        end else if (clear) begin
            lanes_q <= '0;
            cnt_q   <= '0;
        end else if (byte_valid) begin
            lanes_q <= word;
            cnt_q   <= last_lane ? '0 : cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/instr_boot_sequencer.sv
// Loads soft-core IMEM from the HPS PIO pair and sequences the core reset release.
// Optional BOOT_CHECKSUM_EN adds a mod-256 payload checksum verified at COMMIT.
//   state | meaning
//   IDLE  | waiting for boot_loader_i; core reset = not loaded
//   LOAD  | decoding toggle-framed DATA/ADDR/COMMIT commands
//   HOLD  | core still in reset, counting down RESET_HOLD cycles
//   ERR   | load failed; waits for boot_loader_i to drop
module instr_boot_sequencer
    import instr_boot_pkg::*;
#(
    parameter int INSTR_W    = 32,
    parameter int ADDR_W     = 10,
    parameter int RESET_HOLD = 16
) (
    input  logic               clk_clk,
    input  logic               reset_reset,
    input  logic [PIO_W-1:0]   instruction_i,
    input  logic               boot_loader_i,
    output logic               imem_we_o,
    output logic [ADDR_W-1:0]  imem_addr_o,
    output logic [INSTR_W-1:0] imem_wdata_o,
    output logic               core_reset_o,
    output logic               boot_done_o,
    output logic               boot_error_o,
`ifdef BOOT_CHECKSUM_EN
    output logic [7:0]         checksum_o,
`endif
    output logic [ADDR_W:0]    word_count_o
);

    localparam logic [ADDR_W:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

    state_e state_q, state_d;

    logic [PIO_W-1:0]   pio_q;
    logic               boot_q;
    logic               last_toggle_q;
    logic [ADDR_W-1:0]  addr_q;
    logic [7:0]         hold_cnt_q;
    logic               loaded_q;

    logic               cmd_fire;
    cmd_e               cmd;
    logic [7:0]         payload;

    logic               pk_valid;
    logic               pk_clear;
    logic               pk_last;
    logic               pk_partial;
    logic [INSTR_W-1:0] pk_word;

    logic               load_entry;
    logic               abort;
    logic               addr_lo_we;
    logic               addr_hi_we;
    logic               hold_start;
    logic               hold_end;
    logic               word_wr;
    logic               sum_ok;

    assign cmd_fire = pio_q[PIO_TOGGLE] ^ last_toggle_q;
    assign cmd      = cmd_e'(pio_q[PIO_CMD_HI:PIO_CMD_LO]);
    assign payload  = pio_q[PIO_PAY_HI:PIO_PAY_LO];
    assign word_wr  = pk_valid & pk_last;

    boot_word_packer #(
        .INSTR_W (INSTR_W)
    ) u_packer (
        .clk        (clk_clk),
        .rst        (reset_reset),
        .clear      (pk_clear),
        .byte_valid (pk_valid),
        .byte_data  (payload),
        .word       (pk_word),
        .last_lane  (pk_last),
        .partial    (pk_partial)
    );

`ifdef BOOT_CHECKSUM_EN
    logic [7:0] sum_q;

    assign sum_ok     = (payload == sum_q);
    assign checksum_o = sum_q;

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            sum_q <= '0;
        end else if (load_entry) begin
            sum_q <= '0;
        end else if (pk_valid) begin
            sum_q <= sum_q + payload;
        end
    end
`else
    assign sum_ok = 1'b1;
`endif

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A boot_loader_i fall in LOAD takes priority over any command in the same cycle.
    always_comb begin
        state_d    = state_q;
        pk_valid   = 1'b0;
        pk_clear   = 1'b0;
        load_entry = 1'b0;
        abort      = 1'b0;
        addr_lo_we = 1'b0;
        addr_hi_we = 1'b0;
        hold_start = 1'b0;
        hold_end   = 1'b0;
        case (state_q)
            IDLE: begin
                if (boot_q) begin
                    state_d    = LOAD;
                    load_entry = 1'b1;
                    pk_clear   = 1'b1;
                end
            end
            LOAD: begin
                if (!boot_q) begin
                    state_d  = IDLE;
                    abort    = 1'b1;
                    pk_clear = 1'b1;
                end else if (cmd_fire) begin
                    case (cmd)
                        CMD_DATA: begin
                            pk_valid = 1'b1;
                            if (pk_last && (addr_q == '1)) begin
                                state_d = ERR;
                            end
                        end
                        CMD_ADDR_LO: begin
                            addr_lo_we = 1'b1;
                            pk_clear   = 1'b1;
                        end
                        CMD_ADDR_HI: begin
                            addr_hi_we = 1'b1;
                            pk_clear   = 1'b1;
                        end
                        CMD_COMMIT: begin
                            if (pk_partial || !sum_ok) begin
                                state_d = ERR;
                            end else begin
                                state_d    = HOLD;
                                hold_start = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            HOLD: begin
                if (hold_cnt_q == 8'd1) begin
                    state_d  = IDLE;
                    hold_end = 1'b1;
                end
            end
            ERR: begin
                if (!boot_q) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            pio_q         <= '0;
            boot_q        <= 1'b0;
            last_toggle_q <= 1'b0;
        end else begin
            pio_q         <= instruction_i;
            boot_q        <= boot_loader_i;
            last_toggle_q <= pio_q[PIO_TOGGLE];
        end
    end

    // The top address is written but never wrapped; the FSM moves to ERR instead.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            addr_q       <= '0;
            word_count_o <= '0;
            imem_we_o    <= 1'b0;
            imem_addr_o  <= '0;
            imem_wdata_o <= '0;
        end else begin
            imem_we_o <= word_wr;
            if (load_entry) begin
                addr_q       <= '0;
                word_count_o <= '0;
            end else if (word_wr) begin
                imem_addr_o  <= addr_q;
                imem_wdata_o <= pk_word;
                if (addr_q != '1) begin
                    addr_q <= addr_q + 1'b1;
                end
                if (word_count_o != WC_MAX) begin
                    word_count_o <= word_count_o + 1'b1;
                end
            end else if (addr_lo_we) begin
                addr_q[7:0] <= payload;
            end else if (addr_hi_we) begin
                addr_q[ADDR_W-1:8] <= payload[ADDR_W-9:0];
            end
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            hold_cnt_q <= '0;
        end else if (hold_start) begin
            hold_cnt_q <= 8'(RESET_HOLD);
        end else if (state_q == HOLD) begin
            hold_cnt_q <= hold_cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            loaded_q     <= 1'b0;
            boot_done_o  <= 1'b0;
            boot_error_o <= 1'b0;
        end else begin
            if (load_entry) begin
                loaded_q    <= 1'b0;
                boot_done_o <= 1'b0;
            end else if (hold_end) begin
                loaded_q    <= 1'b1;
                boot_done_o <= 1'b1;
            end
            if (load_entry) begin
                boot_error_o <= 1'b0;
            end else if (abort || (state_d == ERR)) begin
                boot_error_o <= 1'b1;
            end
        end
    end

    assign core_reset_o = ~loaded_q;

endmodule

// File: tb/tb_instr_boot_sequencer.sv
// Self-checking bench for instr_boot_sequencer: vector table, hand-written corner sequences
// and randomized load sessions checked against a queue-based reference model.
module tb_instr_boot_sequencer;

    localparam int INSTR_W    = 32;
    localparam int ADDR_W     = 10;
    localparam int RESET_HOLD = 16;
    localparam int LANES      = INSTR_W / 8;
`ifdef BOOT_CHECKSUM_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic [10:0]        instruction;
    logic               boot_loader;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               core_reset;
    logic               boot_done;
    logic               boot_error;
    logic [ADDR_W:0]    word_count;
`ifdef BOOT_CHECKSUM_EN
    logic [7:0]         checksum;
`endif

    always #5 clk = ~clk;

    instr_boot_sequencer #(
        .INSTR_W    (INSTR_W),
        .ADDR_W     (ADDR_W),
        .RESET_HOLD (RESET_HOLD)
    ) dut (
        .clk_clk       (clk),
        .reset_reset   (rst),
        .instruction_i (instruction),
        .boot_loader_i (boot_loader),
        .imem_we_o     (imem_we),
        .imem_addr_o   (imem_addr),
        .imem_wdata_o  (imem_wdata),
        .core_reset_o  (core_reset),
        .boot_done_o   (boot_done),
        .boot_error_o  (boot_error),
`ifdef BOOT_CHECKSUM_EN
        .checksum_o    (checksum),
`endif
        .word_count_o  (word_count)
    );

    int total = 0;
    int bad   = 0;
    logic tog = 1'b0;

    logic [ADDR_W+INSTR_W-1:0] wr_q[$];

    always @(negedge clk) begin
        if (imem_we) wr_q.push_back({imem_addr, imem_wdata});
    end

    // reference model state
    int                        m_addr;
    int                        m_wc;
    logic [7:0]                m_sum;
    logic [7:0]                m_bytes[$];
    logic [ADDR_W+INSTR_W-1:0] m_exp[$];
    bit                        m_live;
    bit                        m_err;
    bit                        m_done;

    typedef struct {
        logic [1:0]         cmd;
        logic [7:0]         pay;
        logic               we;
        logic [ADDR_W-1:0]  addr;
        logic [INSTR_W-1:0] data;
        logic               err;
    } vec_t;

    vec_t vt[14];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cmd(input logic [1:0] c, input logic [7:0] p);
        tog = ~tog;
        instruction = {tog, c, p};
        step();
    endtask

    task automatic model_cmd(input logic [1:0] c, input logic [7:0] p);
        logic [INSTR_W-1:0] w;
        if (!m_live) return;
        case (c)
            2'b00: begin
                m_sum = m_sum + p;
                m_bytes.push_back(p);
                if (m_bytes.size() == LANES) begin
                    w = '0;
                    for (int i = 0; i < LANES; i++) w = w | (INSTR_W'(m_bytes[i]) << (8 * i));
                    m_exp.push_back({ADDR_W'(m_addr), w});
                    if (m_wc < (1 << ADDR_W)) m_wc++;
                    if (m_addr == (1 << ADDR_W) - 1) begin
                        m_err  = 1'b1;
                        m_live = 1'b0;
                    end else begin
                        m_addr++;
                    end
                    m_bytes.delete();
                end
            end
            2'b01: begin
                m_addr = (m_addr / 256) * 256 + int'(p);
                m_bytes.delete();
            end
            2'b10: begin
                m_addr = (int'(p) % (1 << (ADDR_W - 8))) * 256 + (m_addr % 256);
                m_bytes.delete();
            end
            default: begin
                if (m_bytes.size() != 0 || (CHK && p != m_sum)) m_err = 1'b1;
                else m_done = 1'b1;
                m_live = 1'b0;
            end
        endcase
    endtask

    task automatic send_cmd(input logic [1:0] c, input logic [7:0] p);
        drive_cmd(c, p);
        model_cmd(c, p);
    endtask

    task automatic enter_load();
        boot_loader = 1'b1;
        repeat (3) step();
        m_live = 1'b1;
        m_err  = 1'b0;
        m_done = 1'b0;
        m_addr = 0;
        m_wc   = 0;
        m_sum  = 8'h00;
        m_bytes.delete();
        m_exp.delete();
        wr_q.delete();
    endtask

    task automatic apply_vec(input int i);
        drive_cmd(vt[i].cmd, vt[i].pay);
        step();
        check($sformatf("vec%0d_we", i), 64'(imem_we), 64'(vt[i].we));
        if (vt[i].we) begin
            check($sformatf("vec%0d_addr", i), 64'(imem_addr), 64'(vt[i].addr));
            check($sformatf("vec%0d_data", i), 64'(imem_wdata), 64'(vt[i].data));
        end
        check($sformatf("vec%0d_err", i), 64'(boot_error), 64'(vt[i].err));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int ncmd;
        int r;

        vt[0]  = '{2'b00, 8'h11, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[1]  = '{2'b00, 8'h22, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[2]  = '{2'b00, 8'h33, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[3]  = '{2'b00, 8'h44, 1'b1, 10'h000, 32'h44332211, 1'b0};
        vt[4]  = '{2'b01, 8'hFE, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[5]  = '{2'b10, 8'h03, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[6]  = '{2'b00, 8'h00, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[7]  = '{2'b00, 8'h01, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[8]  = '{2'b00, 8'h02, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[9]  = '{2'b00, 8'h03, 1'b1, 10'h3FE, 32'h03020100, 1'b0};
        vt[10] = '{2'b00, 8'h04, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[11] = '{2'b00, 8'h05, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[12] = '{2'b00, 8'h06, 1'b0, 10'h000, 32'h0,        1'b0};
        vt[13] = '{2'b00, 8'h07, 1'b1, 10'h3FF, 32'h07060504, 1'b1};

        rst = 1'b1;
        boot_loader = 1'b0;
        instruction = '0;
        repeat (3) step();
        check("rst_core_reset", 64'(core_reset), 64'd1);
        check("rst_done", 64'(boot_done), 64'd0);
        check("rst_error", 64'(boot_error), 64'd0);
        check("rst_we", 64'(imem_we), 64'd0);
        check("rst_word_count", 64'(word_count), 64'd0);
        rst = 1'b0;

        // idle: toggles without boot_loader must never write
        for (int i = 0; i < 8; i++) drive_cmd(2'b00, 8'(i));
        repeat (10) step();
        check("idle_writes", 64'(wr_q.size()), 64'd0);
        check("idle_core_reset", 64'(core_reset), 64'd1);
        check("idle_error", 64'(boot_error), 64'd0);

        // basic load of one word then commit
        enter_load();
        for (int i = 0; i < 4; i++) apply_vec(i);
        drive_cmd(2'b11, 8'hAA);
        boot_loader = 1'b0;
        k = 1;
        while (core_reset && k < 60) begin
            step();
            k++;
        end
        check("release_latency", 64'(k), 64'(RESET_HOLD + 2));
        check("commit_done", 64'(boot_done), 64'd1);
        check("commit_error", 64'(boot_error), 64'd0);
        check("commit_wc", 64'(word_count), 64'd1);

        // top-of-memory writes then error
        enter_load();
        check("reload_done_clear", 64'(boot_done), 64'd0);
        check("reload_core_reset", 64'(core_reset), 64'd1);
        for (int i = 4; i < 14; i++) apply_vec(i);
        check("top_core_reset", 64'(core_reset), 64'd1);
        check("top_wc", 64'(word_count), 64'd2);
        drive_cmd(2'b00, 8'h99);
        repeat (4) step();
        check("err_ignores_cmd", 64'(wr_q.size()), 64'd2);
        boot_loader = 1'b0;
        repeat (4) step();
        check("top_err_sticky", 64'(boot_error), 64'd1);
        check("top_idle_core_reset", 64'(core_reset), 64'd1);

        // partial word at commit
        enter_load();
        check("partial_err_cleared", 64'(boot_error), 64'd0);
        drive_cmd(2'b00, 8'hA1);
        drive_cmd(2'b00, 8'hA2);
        drive_cmd(2'b00, 8'hA3);
        drive_cmd(2'b11, 8'h00);
        repeat (2) step();
        check("partial_err", 64'(boot_error), 64'd1);
        check("partial_no_write", 64'(wr_q.size()), 64'd0);
        boot_loader = 1'b0;
        repeat (4) step();
        check("partial_idle_core_reset", 64'(core_reset), 64'd1);
        check("partial_done", 64'(boot_done), 64'd0);

        // abort in the same cycle as a fifth toggle
        enter_load();
        drive_cmd(2'b00, 8'hA1);
        drive_cmd(2'b00, 8'hA2);
        drive_cmd(2'b00, 8'hA3);
        drive_cmd(2'b00, 8'hA4);
        tog = ~tog;
        instruction = {tog, 2'b00, 8'h55};
        boot_loader = 1'b0;
        repeat (4) step();
        check("abort_writes", 64'(wr_q.size()), 64'd1);
        if (wr_q.size() > 0) check("abort_word", 64'(wr_q[0]), 64'({10'h000, 32'hA4A3A2A1}));
        check("abort_error", 64'(boot_error), 64'd1);
        check("abort_core_reset", 64'(core_reset), 64'd1);
        check("abort_wc", 64'(word_count), 64'd1);
        for (int i = 0; i < 4; i++) drive_cmd(2'b00, 8'h66);
        repeat (3) step();
        check("abort_idle_ignores", 64'(wr_q.size()), 64'd1);

`ifdef BOOT_CHECKSUM_EN
        enter_load();
        drive_cmd(2'b00, 8'h80);
        drive_cmd(2'b00, 8'h90);
        drive_cmd(2'b00, 8'h01);
        drive_cmd(2'b00, 8'h02);
        step();
        check("cks_value", 64'(checksum), 64'h13);
        drive_cmd(2'b11, 8'h13);
        boot_loader = 1'b0;
        repeat (RESET_HOLD + 6) step();
        check("cks_good_done", 64'(boot_done), 64'd1);
        check("cks_good_error", 64'(boot_error), 64'd0);
        check("cks_good_core_reset", 64'(core_reset), 64'd0);
        enter_load();
        drive_cmd(2'b00, 8'h80);
        drive_cmd(2'b00, 8'h90);
        drive_cmd(2'b00, 8'h01);
        drive_cmd(2'b00, 8'h02);
        drive_cmd(2'b11, 8'h14);
        boot_loader = 1'b0;
        repeat (RESET_HOLD + 6) step();
        check("cks_bad_done", 64'(boot_done), 64'd0);
        check("cks_bad_error", 64'(boot_error), 64'd1);
        check("cks_bad_core_reset", 64'(core_reset), 64'd1);
`endif

        // randomized sessions against the reference model
        for (int s = 0; s < 8; s++) begin
            enter_load();
            ncmd = $urandom_range(8, 40);
            for (int c = 0; c < ncmd; c++) begin
                r = $urandom_range(0, 19);
                if (r == 17) send_cmd(2'b01, 8'($urandom_range(0, 255)));
                else if (r == 18) send_cmd(2'b10, 8'($urandom_range(0, 3)));
                else send_cmd(2'b00, 8'($urandom_range(0, 255)));
                repeat ($urandom_range(0, 2)) step();
            end
            if ($urandom_range(0, 1) == 1) begin
                for (int c = 0; c < LANES && m_live && m_bytes.size() != 0; c++)
                    send_cmd(2'b00, 8'($urandom_range(0, 255)));
            end
            send_cmd(2'b11, m_sum);
            boot_loader = 1'b0;
            if (m_live) begin
                m_err  = 1'b1;
                m_live = 1'b0;
            end
            repeat (RESET_HOLD + 6) step();
            check($sformatf("rnd%0d_nwrites", s), 64'(wr_q.size()), 64'(m_exp.size()));
            for (int i = 0; i < m_exp.size() && i < wr_q.size(); i++)
                check($sformatf("rnd%0d_write%0d", s, i), 64'(wr_q[i]), 64'(m_exp[i]));
            check($sformatf("rnd%0d_wc", s), 64'(word_count), 64'(m_wc));
            check($sformatf("rnd%0d_done", s), 64'(boot_done), 64'(m_done));
            check($sformatf("rnd%0d_error", s), 64'(boot_error), 64'(m_err));
            check($sformatf("rnd%0d_core_reset", s), 64'(core_reset), 64'(!m_done));
        end

        // asynchronous reset in the middle of a load
        enter_load();
        drive_cmd(2'b00, 8'h12);
        drive_cmd(2'b00, 8'h34);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_core_reset", 64'(core_reset), 64'd1);
        check("midrst_done", 64'(boot_done), 64'd0);
        check("midrst_wc", 64'(word_count), 64'd0);
        boot_loader = 1'b0;
        step();
        rst = 1'b0;
        repeat (4) step();
        check("midrst_error", 64'(boot_error), 64'd0);
        check("midrst_writes", 64'(wr_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
